fetch_pc_gen: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It is the producer of the IF→ID bus {ce, pc} and the consumer of the ID branch bus {br_e, br_addr}. It owns the PC register and drives the instruction SRAM request, whose data ID samples one cycle later. It absorbs branch redirects that arrive while the PC stage is stalled, so no redirect is lost.

---
 rtl/fetch_pc_gen_if.sv | 35 +++
 rtl/fetch_pc_gen.sv | 82 ++++++++
 tb/tb_fetch_pc_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_gen_if.sv
// rtl/fetch_pc_gen_if.sv - IF stage bundle: stall/branch inputs, IF->ID bus and instruction SRAM request
interface fetch_pc_gen_if #(
    parameter int STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic [32:0]        br_bus;
    logic [32:0]        if_to_id_bus;
    logic               inst_sram_en;
    logic [3:0]         inst_sram_wen;
    logic [31:0]        inst_sram_addr;
    logic [31:0]        inst_sram_wdata;
    logic               redirect_pending;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output redirect_pending
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  redirect_pending
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - IF stage PC generator with buffered redirect across PC-stage stalls
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
    parameter int          STALL_W  = 6
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        stall_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;

    assign stall_pc = bus.stall[0];
    assign br_e     = bus.br_bus[32];
    assign br_addr  = bus.br_bus[31:0];

    // Live redirect beats the buffered one, which beats sequential fetch.
    always_comb begin
        if (br_e)
            next_pc = br_addr;
        else if (pend_valid_q)
            next_pc = pend_addr_q;
        else
            next_pc = pc_q + 32'd4;
    end

    always_comb begin
        state_d      = stall_pc ? HOLD : RUN;
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (!stall_pc) begin
            pc_d         = next_pc;
            ce_d         = 1'b1;
            pend_valid_d = 1'b0;
        end else if (br_e) begin
            // Held stage: remember the newest target until the stall lifts.
            pend_valid_d = 1'b1;
            pend_addr_d  = br_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign bus.if_to_id_bus     = {ce_q, pc_q};
    assign bus.inst_sram_en     = ce_q;
    assign bus.inst_sram_addr   = pc_q;
    assign bus.inst_sram_wen    = 4'b0;
    assign bus.inst_sram_wdata  = 32'b0;
    assign bus.redirect_pending = pend_valid_q;

    // Upper stall bits belong to later stages; state_q is a debug view only.
    logic unused_ok;
    assign unused_ok = ^{bus.stall[STALL_W-1:1], state_q};

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - scoreboard bench for fetch_pc_gen
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
    localparam int          STALL_W  = 6;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    logic [31:0] m_pc = RESET_PC;
    logic        m_ce = 1'b0;
    logic        m_pv = 1'b0;
    logic [31:0] m_pa = 32'b0;

    fetch_pc_gen_if #(.STALL_W(STALL_W)) bus ();

    fetch_pc_gen #(.RESET_PC(RESET_PC), .STALL_W(STALL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, then compare after the edge.
    task automatic step(input logic r, input logic st, input logic be, input logic [31:0] ba);
        exp_t e;
        rst        = r;
        bus.stall  = {5'b0, st};
        bus.br_bus = {be, ba};
        if (r) begin
            m_pc = RESET_PC; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'b0;
        end else if (!st) begin
            m_pc = be ? ba : (m_pv ? m_pa : m_pc + 32'd4);
            m_ce = 1'b1;
            m_pv = 1'b0;
        end else if (be) begin
            m_pv = 1'b1;
            m_pa = ba;
        end
        e.ce = m_ce; e.pc = m_pc; e.pend = m_pv;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("if_to_id_bus", bus.if_to_id_bus, {e.ce, e.pc});
        chk("sram_addr", {1'b0, bus.inst_sram_addr}, {1'b0, e.pc});
        chk("sram_en", {32'b0, bus.inst_sram_en}, {32'b0, e.ce});
        chk("redirect_pending", {32'b0, bus.redirect_pending}, {32'b0, e.pend});
        chk("sram_wen_wdata", {1'b0, bus.inst_sram_wdata | {28'b0, bus.inst_sram_wen}}, 33'b0);
    endtask

    task automatic want(input string tag, input logic ce, input logic [31:0] pc, input logic pend);
        chk(tag, {bus.redirect_pending, bus.if_to_id_bus}, {pend, ce, pc});
    endtask

    initial begin
        bus.stall  = '0;
        bus.br_bus = '0;
        step(1, 0, 0, 32'h0);
        want("reset", 1'b0, RESET_PC, 1'b0);
        step(1, 0, 1, 32'h1234_5678);
        want("reset_br_ignored", 1'b0, RESET_PC, 1'b0);

        step(0, 0, 0, 32'h0);  want("first_fetch", 1'b1, 32'hBFC0_0000, 1'b0);
        step(0, 0, 0, 32'h0);  want("seq_4", 1'b1, 32'hBFC0_0004, 1'b0);
        step(0, 0, 0, 32'h0);  want("seq_8", 1'b1, 32'hBFC0_0008, 1'b0);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0);
            want("stall_hold", 1'b1, 32'hBFC0_0008, 1'b0);
        end
        step(0, 0, 0, 32'h0);  want("stall_release", 1'b1, 32'hBFC0_000C, 1'b0);
        step(0, 0, 0, 32'h0);  want("seq_10", 1'b1, 32'hBFC0_0010, 1'b0);

        step(0, 0, 1, 32'hBFC0_0100); want("live_branch", 1'b1, 32'hBFC0_0100, 1'b0);
        step(0, 0, 0, 32'h0);         want("after_branch", 1'b1, 32'hBFC0_0104, 1'b0);

        step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h8000_0040); want("pend_capture", 1'b1, 32'hBFC0_0104, 1'b1);
        step(0, 1, 1, 32'h8000_0080); want("pend_overwrite", 1'b1, 32'hBFC0_0104, 1'b1);
        step(0, 0, 0, 32'h0);         want("pend_used", 1'b1, 32'h8000_0080, 1'b0);
        step(0, 0, 0, 32'h0);         want("pend_after", 1'b1, 32'h8000_0084, 1'b0);

        step(0, 1, 1, 32'h8000_0040); want("conflict_pend", 1'b1, 32'h8000_0084, 1'b1);
        step(0, 0, 1, 32'h8000_0200); want("live_beats_pend", 1'b1, 32'h8000_0200, 1'b0);
        step(0, 0, 0, 32'h0);         want("conflict_after", 1'b1, 32'h8000_0204, 1'b0);

        step(0, 1, 1, 32'h8000_0040); want("hold_pend", 1'b1, 32'h8000_0204, 1'b1);
        step(1, 1, 0, 32'h0);         want("rst_mid_hold", 1'b0, RESET_PC, 1'b0);
        step(0, 0, 0, 32'h0);         want("restart", 1'b1, 32'hBFC0_0000, 1'b0);

        step(0, 0, 1, 32'hFFFF_FFFC); want("to_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(0, 0, 0, 32'h0);         want("wrap", 1'b1, 32'h0000_0000, 1'b0);
        step(0, 0, 1, 32'h8000_0002); want("misaligned", 1'b1, 32'h8000_0002, 1'b0);
        step(0, 0, 0, 32'h0);         want("misaligned_seq", 1'b1, 32'h8000_0006, 1'b0);

        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFFC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
